// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data-memory request/response bus between mem_access and the memory
interface mem_access_if;
    logic        req;
    logic [31:0] addr;
    logic        ren;
    logic        wen;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, addr, ren, wen, mask, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, addr, ren, wen, mask, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM stage: data-memory handshake, store lanes, load extension (option: MEM_MISALIGN_TRAP_EN)
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_store_data,
    input  logic [2:0]        i_funct3,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    output logic              o_stall,
    mem_access_if.master      dmem,
    output logic              o_valid,
    output logic [31:0]       o_load_data,
    output logic [31:0]       o_dmem_rdata,
    output logic              o_err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] load_q, load_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        first_q;

    logic        active;
    logic        memop;
    logic        is_store;
    logic        misalign;
    logic        idle_op;
    logic        req;
    logic        out_done;
    logic [3:0]  st_mask;
    logic [31:0] st_wdata;

    // Outputs stay quiet while in reset and for the first cycle after it.
    assign active   = !i_rst && !first_q;
    assign memop    = i_valid && (i_mem_read || i_mem_write);
    assign is_store = i_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                      ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                            input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return w;
        endcase
    endfunction

    // Byte enables and lane-replicated store data for the current access size.
    always_comb begin
        st_mask  = 4'hF;
        st_wdata = i_store_data;
        case (i_funct3[1:0])
            2'b00: begin
                st_mask  = 4'b0001 << i_addr[1:0];
                st_wdata = {4{i_store_data[7:0]}};
            end
            2'b01: begin
                st_mask  = i_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{i_store_data[15:0]}};
            end
            default: begin
                st_mask  = 4'hF;
                st_wdata = i_store_data;
            end
        endcase
    end

    // Access sequencing; timeout wins over a handshake arriving on the final counted cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (active && memop) begin
                    cnt_d   = 8'd0;
                    load_d  = 32'd0;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    if (misalign) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (dmem.ready) begin
                        state_d = is_store ? S_DONE : S_RESP;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (dmem.ready) begin
                        state_d = is_store ? S_DONE : S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (dmem.rvalid) begin
                    rdata_d = dmem.rdata;
                    load_d  = extract(dmem.rdata, i_addr[1:0], i_funct3);
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and captured-result registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            load_q  <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Marks the first cycle after reset so outputs can be held low for it.
    always_ff @(posedge i_clk) begin
        first_q <= i_rst;
    end

    assign idle_op  = active && (state_q == S_IDLE) && memop;
    assign req      = (idle_op && !misalign) || (active && (state_q == S_REQ));
    assign out_done = active && (state_q == S_DONE);

    assign o_stall = idle_op || (active && ((state_q == S_REQ) || (state_q == S_RESP)));
    assign o_valid = out_done || (active && (state_q == S_IDLE) && i_valid && !memop);

    assign o_load_data  = out_done ? load_q  : 32'd0;
    assign o_dmem_rdata = out_done ? rdata_q : 32'd0;
    assign o_err        = out_done && err_q;

    assign dmem.req   = req;
    assign dmem.ren   = req && !is_store;
    assign dmem.wen   = req && is_store;
    assign dmem.addr  = req ? {i_addr[31:2], 2'b00} : 32'd0;
    assign dmem.mask  = req ? (is_store ? st_mask : 4'hF) : 4'h0;
    assign dmem.wdata = (req && is_store) ? st_wdata : 32'd0;
endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - randomized self-checking bench for mem_access against a transaction model
module tb_mem_access;
    localparam int TO = 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [31:0] i_addr;
    logic [31:0] i_store_data;
    logic [2:0]  i_funct3;
    logic        i_mem_read;
    logic        i_mem_write;
    logic        o_stall;
    logic        o_valid;
    logic [31:0] o_load_data;
    logic [31:0] o_dmem_rdata;
    logic        o_err;

    mem_access_if dmem();

    mem_access #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .i_addr       (i_addr),
        .i_store_data (i_store_data),
        .i_funct3     (i_funct3),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .o_stall      (o_stall),
        .dmem         (dmem),
        .o_valid      (o_valid),
        .o_load_data  (o_load_data),
        .o_dmem_rdata (o_dmem_rdata),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic        chk = 1'b0;
    logic        e_stall, e_req, e_ren, e_wen, e_valid, e_err;
    logic [31:0] e_addr, e_wdata, e_load, e_rdata;
    logic [3:0]  e_mask;

    logic [2:0] lf3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_extract(input logic [31:0] w, input logic [1:0] a,
                                              input logic [2:0] f3);
        int unsigned b, h;
        logic [1:0] al;
        al = a;
        b = (w >> (8 * al)) & 32'hFF;
        h = (w >> (16 * al[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'b001:  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [31:0] a);
        if (f3[1:0] == 2'b00) return 4'(1 << a[1:0]);
        if (f3[1:0] == 2'b01) return a[1] ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        if (f3[1:0] == 2'b00) return (sd & 32'hFF) * 32'h0101_0101;
        if (f3[1:0] == 2'b01) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    always @(negedge i_clk) begin
        if (chk) begin
            check("stall", {31'b0, o_stall}, {31'b0, e_stall});
            check("valid", {31'b0, o_valid}, {31'b0, e_valid});
            check("req",   {31'b0, dmem.req}, {31'b0, e_req});
            check("ren",   {31'b0, dmem.ren}, {31'b0, e_ren});
            check("wen",   {31'b0, dmem.wen}, {31'b0, e_wen});
            check("addr",  dmem.addr, e_addr);
            check("mask",  {28'b0, dmem.mask}, {28'b0, e_mask});
            check("wdata", dmem.wdata, e_wdata);
            check("err",   {31'b0, o_err}, {31'b0, e_err});
            check("load",  o_load_data, e_load);
            check("rdata", o_dmem_rdata, e_rdata);
        end
    end

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic zero_exp();
        e_stall = 0; e_req = 0; e_ren = 0; e_wen = 0; e_valid = 0; e_err = 0;
        e_addr = 0; e_wdata = 0; e_load = 0; e_rdata = 0; e_mask = 0;
    endtask

    // One instruction: dr = cycles until ready, dv = extra RESP cycles before rvalid.
    task automatic do_op(input bit vld, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [2:0] f3, input int dr, input int dv,
                         input logic [31:0] rdata);
        bit memop, st, mis, tmo;
        int done;
        memop = vld && (rd || wr);
        st    = wr;
        mis   = 0;
        tmo   = 0;
`ifdef MEM_MISALIGN_TRAP_EN
        mis = memop && (((f3[1:0] == 2'b01) && addr[0]) || ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00)));
`endif
        if (!memop)   done = 0;
        else if (mis) done = 1;
        else if (st) begin
            tmo  = (dr >= TO);
            done = tmo ? TO + 1 : dr + 1;
        end else begin
            tmo  = (dr + dv + 1 >= TO);
            done = tmo ? TO + 1 : dr + dv + 2;
        end
        i_valid = vld; i_mem_read = rd; i_mem_write = wr;
        i_addr = addr; i_store_data = sd; i_funct3 = f3;
        for (int c = 0; c <= done; c++) begin
            dmem.ready  = memop && !mis && (c == dr) && (c < done);
            dmem.rvalid = 1'b0;
            dmem.rdata  = $urandom;
            if (memop && !st && !mis && (c == dr + 1 + dv) && (c < done)) begin
                dmem.rvalid = 1'b1;
                dmem.rdata  = rdata;
            end else if ((c <= dr) && (c < done) && ($urandom_range(0, 1) == 1)) begin
                dmem.rvalid = 1'b1;
            end
            zero_exp();
            if (c < done) begin
                e_stall = 1;
                e_req   = !mis && (c <= dr);
            end else begin
                e_valid = vld;
                e_err   = tmo || mis;
                if (memop && !st && !tmo && !mis) begin
                    e_load  = m_extract(rdata, addr[1:0], f3);
                    e_rdata = rdata;
                end
            end
            e_ren   = e_req && !st;
            e_wen   = e_req && st;
            e_addr  = e_req ? {addr[31:2], 2'b00} : 32'd0;
            e_mask  = e_req ? (st ? m_mask(f3, addr) : 4'hF) : 4'h0;
            e_wdata = (e_req && st) ? m_wdata(f3, sd) : 32'd0;
            chk = 1'b1;
            next_cycle();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        check("pin_lb",    m_extract(32'h80FF_0000, 2'd3, 3'b000), 32'hFFFF_FF80);
        check("pin_lhu",   m_extract(32'h1234_F00D, 2'd0, 3'b101), 32'h0000_F00D);
        check("pin_lh",    m_extract(32'h8000_1234, 2'd2, 3'b001), 32'hFFFF_8000);
        check("pin_lbu",   m_extract(32'h0000_9A00, 2'd1, 3'b100), 32'h0000_009A);
        check("pin_shm",   {28'b0, m_mask(3'b001, 32'h102)}, 32'h0000_000C);
        check("pin_shd",   m_wdata(3'b001, 32'h0000_BEEF), 32'hBEEF_BEEF);
        check("pin_sbm",   {28'b0, m_mask(3'b000, 32'h7)}, 32'h0000_0008);

        // Reset with a memop pending, then the quiet first cycle after reset.
        i_rst = 1; i_valid = 1; i_mem_read = 1; i_mem_write = 0;
        i_addr = 32'h40; i_store_data = 0; i_funct3 = 3'b010;
        dmem.ready = 1; dmem.rvalid = 1; dmem.rdata = 32'hDEAD_BEEF;
        zero_exp(); chk = 1;
        next_cycle();
        next_cycle();
        i_rst = 0;
        next_cycle();

        // Directed scenarios.
        do_op(1, 0, 0, 32'h55, 32'h0, 3'b000, 0, 0, 32'h0);
        do_op(1, 1, 0, 32'h103, 32'h0, 3'b000, 0, 0, 32'h80FF_0000);
        do_op(1, 0, 1, 32'h102, 32'h0000_BEEF, 3'b001, 3, 0, 32'h0);
        do_op(1, 1, 0, 32'h200, 32'h0, 3'b101, 0, 0, 32'h1234_F00D);
        do_op(1, 1, 0, 32'h204, 32'h0, 3'b010, 0, 0, 32'hCAFE_0001);
        do_op(1, 1, 0, 32'h208, 32'h0, 3'b010, 0, 0, 32'hCAFE_0002);
        do_op(0, 0, 0, 32'h0, 32'h0, 3'b000, 0, 0, 32'h0);
        do_op(1, 1, 0, 32'h300, 32'h0, 3'b010, 100, 0, 32'h1111_2222);
        do_op(1, 0, 1, 32'h304, 32'h1234_5678, 3'b010, TO, 0, 32'h0);
        do_op(1, 0, 1, 32'h308, 32'h1234_5678, 3'b010, TO - 1, 0, 32'h0);
        do_op(1, 1, 1, 32'h30D, 32'h0000_00A5, 3'b000, 1, 0, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
        do_op(1, 1, 0, 32'h2, 32'h0, 3'b010, 0, 0, 32'h0);
`endif

        // Reset while waiting in RESP: next cycles must be silent with no beat.
        i_valid = 1; i_mem_read = 1; i_mem_write = 0; i_addr = 32'h400; i_funct3 = 3'b010;
        dmem.ready = 1; dmem.rvalid = 0;
        zero_exp(); e_stall = 1; e_req = 1; e_ren = 1; e_addr = 32'h400; e_mask = 4'hF;
        next_cycle();
        dmem.ready = 0;
        zero_exp(); e_stall = 1;
        next_cycle();
        i_rst = 1; dmem.rvalid = 1; dmem.rdata = 32'h5A5A_5A5A;
        zero_exp();
        next_cycle();
        i_rst = 0; dmem.rvalid = 0;
        next_cycle();

        // Randomized instruction stream, back to back.
        for (int n = 0; n < 300; n++) begin
            int kind, dr, dv;
            logic [2:0] f3;
            kind = $urandom_range(0, 9);
            dr   = ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(0, 3);
            dv   = $urandom_range(0, 2);
            f3   = lf3[$urandom_range(0, 4)];
            case (kind)
                0:       do_op(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom, f3, dr, dv, $urandom);
                1, 2:    do_op(1, 0, 0, $urandom, $urandom, f3, dr, dv, $urandom);
                3, 4, 5: do_op(1, 1, 0, $urandom, $urandom, f3, dr, dv, $urandom);
                8:       do_op(1, 1, 1, $urandom, $urandom, 3'($urandom_range(0, 2)), dr, dv, $urandom);
                default: do_op(1, 0, 1, $urandom, $urandom, 3'($urandom_range(0, 2)), dr, dv, $urandom);
            endcase
        end

        chk = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
